// File: rtl/preg_free_list_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : preg_free_list_ctrl_pkg
// Brief  : Shared sizes and types for the physical-register free list.
// Rev    : 1.0  initial release
// ============================================================================
package preg_free_list_ctrl_pkg;

    localparam int PREG_COUNT = 64;
    localparam int ARCH_REGS  = 32;
    localparam int PREG_W     = $clog2(PREG_COUNT);
    localparam int FL_DEPTH   = PREG_COUNT - ARCH_REGS;
    localparam int FL_IDX_W   = $clog2(FL_DEPTH);
    // One extra MSB acts as the wrap bit so full and empty are distinguishable.
    localparam int FL_PTR_W   = FL_IDX_W + 1;

    typedef enum logic [0:0] {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_t;

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage
`default_nettype wire

// File: rtl/preg_free_list_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : preg_free_list_ctrl_if
// Brief  : Rename/commit side bundle of the free-list controller.
// Rev    : 1.0  initial release
// ============================================================================
interface preg_free_list_ctrl_if;
    import preg_free_list_ctrl_pkg::*;

    logic    ready_o;
    logic    alloc_req_i;
    logic    alloc_gnt_o;
    preg_t   alloc_preg_o;
    logic    commit_alloc_i;
    logic    free_valid_i;
    preg_t   free_preg_i;
    logic    flush_i;
    fl_ptr_t free_count_o;
    logic    full_o;

    // Free-list side
    modport slave (
        output ready_o, alloc_gnt_o, alloc_preg_o, free_count_o, full_o,
        input  alloc_req_i, commit_alloc_i, free_valid_i, free_preg_i, flush_i
    );

    // Pipeline side
    modport master (
        input  ready_o, alloc_gnt_o, alloc_preg_o, free_count_o, full_o,
        output alloc_req_i, commit_alloc_i, free_valid_i, free_preg_i, flush_i
    );

endinterface
`default_nettype wire

// File: rtl/preg_free_list_ctrl_fl_ptr_ring.sv
`default_nettype none
// ============================================================================
// Module : fl_ptr_ring
// Brief  : Free-list storage with tail pointer and a read port at the head.
// Rev    : 1.0  initial release
// ============================================================================
module fl_ptr_ring
    import preg_free_list_ctrl_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  preg_t   push_preg_i,
    input  fl_ptr_t rd_ptr_i,
    output preg_t   rd_preg_o,
    output fl_ptr_t tail_o,
    output fl_ptr_t tail_d_o
);

    localparam fl_ptr_t PTR_ONE = fl_ptr_t'(1);

    preg_t   mem_q [FL_DEPTH];
    fl_ptr_t tail_q;
    fl_ptr_t tail_d;

    // Tail advances on every accepted write
    always_comb begin
        tail_d = tail_q;
        if (push_i) begin
            tail_d = tail_q + PTR_ONE;
        end
    end

    // Tail pointer register, cleared on reset so init refills from slot 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tail_q <= '0;
        end else begin
            tail_q <= tail_d;
        end
    end

    // Storage write at the tail slot; contents need no reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) begin
            mem_q[tail_q[FL_IDX_W-1:0]] <= push_preg_i;
        end
    end

    assign rd_preg_o = mem_q[rd_ptr_i[FL_IDX_W-1:0]];
    assign tail_o    = tail_q;
    assign tail_d_o  = tail_d;

endmodule
`default_nettype wire

// File: rtl/preg_free_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module : preg_free_list_ctrl
// Brief  : Circular physical-register free list with speculative and
//          architectural heads, one-cycle flush rewind and self-init.
// Rev    : 1.0  initial release
// ============================================================================
module preg_free_list_ctrl
    import preg_free_list_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    preg_free_list_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_INIT   = FL_INIT;
    localparam logic [0:0] ST_RUN    = FL_RUN;
    localparam fl_ptr_t    PTR_ONE   = fl_ptr_t'(1);
    localparam fl_ptr_t    PTR_DEPTH = fl_ptr_t'(FL_DEPTH);
    localparam fl_ptr_t    INIT_LAST = fl_ptr_t'(FL_DEPTH - 1);

    logic [0:0] state_q, state_d;
    fl_ptr_t    spec_head_q, spec_head_d;
    fl_ptr_t    arch_head_q, arch_head_d;
    fl_ptr_t    tail_q, tail_d;
    fl_ptr_t    spec_count, arch_count, spec_count_d;
    fl_ptr_t    free_count_q;
    logic       full_q;
    logic       run, gnt, free_ok, push;
    preg_t      push_preg, init_preg, head_preg;

    assign run        = (state_q == ST_RUN);
    assign spec_count = tail_q - spec_head_q;
    assign arch_count = tail_q - arch_head_q;

    // During init the tail doubles as the init counter: slot i gets ARCH_REGS+i.
    assign init_preg  = preg_t'(ARCH_REGS) + preg_t'(tail_q[FL_IDX_W-1:0]);
    // Preg 0 is never a legal free target, and a full architectural list cannot accept more.
    assign free_ok    = run && bus.free_valid_i && (bus.free_preg_i != '0)
                        && (arch_count != PTR_DEPTH);
    assign push       = run ? free_ok : 1'b1;
    assign push_preg  = run ? bus.free_preg_i : init_preg;

    // Grant only from entries already present at the start of the cycle
    assign gnt = run && bus.alloc_req_i && !bus.flush_i && (spec_count != '0);

    fl_ptr_ring u_ring (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_preg_i (push_preg),
        .rd_ptr_i    (spec_head_q),
        .rd_preg_o   (head_preg),
        .tail_o      (tail_q),
        .tail_d_o    (tail_d)
    );

    // Next-state for FSM and head pointers; flush rewinds to post-commit head
    always_comb begin
        state_d     = state_q;
        spec_head_d = spec_head_q;
        arch_head_d = arch_head_q;
        if (run) begin
            if (bus.commit_alloc_i) begin
                arch_head_d = arch_head_q + PTR_ONE;
            end
            if (bus.flush_i) begin
                spec_head_d = arch_head_d;
            end else if (gnt) begin
                spec_head_d = spec_head_q + PTR_ONE;
            end
        end else if (tail_q == INIT_LAST) begin
            state_d = ST_RUN;
        end
        spec_count_d = tail_d - spec_head_d;
    end

    // State, heads and registered occupancy outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            spec_head_q  <= '0;
            arch_head_q  <= '0;
            free_count_q <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            spec_head_q  <= spec_head_d;
            arch_head_q  <= arch_head_d;
            free_count_q <= spec_count_d;
            full_q       <= (spec_count_d == PTR_DEPTH);
        end
    end

    // Protocol checks on the commit-side inputs
    always_ff @(posedge clk_i) begin
        if (!rst_i && run) begin
            if (bus.free_valid_i) begin
                assert (bus.free_preg_i != '0)
                    else $warning("preg_free_list_ctrl: free of preg 0 ignored");
                if (bus.free_preg_i != '0) begin
                    assert (arch_count != PTR_DEPTH)
                        else $fatal(1, "preg_free_list_ctrl: free-list overflow");
                end
            end
            if (bus.commit_alloc_i) begin
                assert (arch_head_q != spec_head_q)
                    else $fatal(1, "preg_free_list_ctrl: arch head passed spec head");
            end
        end
    end

    assign bus.ready_o      = run;
    assign bus.alloc_gnt_o  = gnt;
    assign bus.alloc_preg_o = (run && (spec_count != '0)) ? head_preg : '0;
    assign bus.free_count_o = free_count_q;
    assign bus.full_o       = full_q;

endmodule
`default_nettype wire

// File: tb/tb_preg_free_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_preg_free_list_ctrl
// Brief  : Scoreboard bench for the physical-register free list.
// Rev    : 1.0  initial release
// ============================================================================
module tb_preg_free_list_ctrl;
    import preg_free_list_ctrl_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;

    preg_free_list_ctrl_if bus();

    preg_free_list_ctrl dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int free_q[$];   // model: allocatable pregs in order
    int infl_q[$];   // model: allocated, not yet committed
    int sb_q[$];     // expected grant pregs
    bit m_run = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.alloc_req_i    = 1'b0;
        bus.free_valid_i   = 1'b0;
        bus.free_preg_i    = '0;
        bus.commit_alloc_i = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    // One clock of stimulus with model update and checks
    task automatic cycle(input bit req, input bit fv, input int fp, input bit ca, input bit fl);
        bit exp_gnt;
        int arch_pre;
        @(negedge clk_i);
        bus.alloc_req_i    = req;
        bus.free_valid_i   = fv;
        bus.free_preg_i    = preg_t'(fp);
        bus.commit_alloc_i = ca;
        bus.flush_i        = fl;
        #1;
        arch_pre = free_q.size() + infl_q.size();
        exp_gnt  = m_run && req && !fl && (free_q.size() != 0);
        if (exp_gnt) sb_q.push_back(free_q[0]);
        check_eq("alloc_gnt", int'(bus.alloc_gnt_o), int'(exp_gnt));
        if (bus.alloc_gnt_o) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected_grant", int'(bus.alloc_preg_o), -1);
            else                  check_eq("sb_grant_preg", int'(bus.alloc_preg_o), sb_q.pop_front());
        end else begin
            check_eq("head_preg", int'(bus.alloc_preg_o),
                     (m_run && free_q.size() != 0) ? free_q[0] : 0);
        end
        if (exp_gnt) infl_q.push_back(free_q.pop_front());
        if (m_run && ca && infl_q.size() != 0) void'(infl_q.pop_front());
        if (m_run && fl) begin
            free_q = {infl_q, free_q};
            infl_q.delete();
        end
        if (m_run && fv && fp != 0 && arch_pre != FL_DEPTH) free_q.push_back(fp);
        @(posedge clk_i);
        #1;
        check_eq("free_count", int'(bus.free_count_o), free_q.size());
        check_eq("full", int'(bus.full_o), int'(free_q.size() == FL_DEPTH));
    endtask

    // Reset, optionally check reset outputs, then wait for init to finish
    task automatic do_reset(input bit chk_vals);
        int cyc;
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_idle();
        m_run = 1'b0;
        free_q.delete();
        infl_q.delete();
        sb_q.delete();
        @(negedge clk_i);
        if (chk_vals) begin
            check_eq("rst_ready", int'(bus.ready_o), 0);
            check_eq("rst_gnt", int'(bus.alloc_gnt_o), 0);
            check_eq("rst_preg", int'(bus.alloc_preg_o), 0);
            check_eq("rst_count", int'(bus.free_count_o), 0);
            check_eq("rst_full", int'(bus.full_o), 0);
        end
        rst_i = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            if (bus.ready_o) begin
                cyc = k;
                break;
            end
        end
        check_eq("init_latency", cyc, FL_DEPTH);
        check_eq("init_count", int'(bus.free_count_o), FL_DEPTH);
        check_eq("init_full", int'(bus.full_o), 1);
        check_eq("init_head_preg", int'(bus.alloc_preg_o), ARCH_REGS);
        for (int p = ARCH_REGS; p < PREG_COUNT; p++) free_q.push_back(p);
        m_run = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();

        // Reset values, init latency, then idle
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);

        // Drain the list, then one request on empty
        for (int i = 0; i < FL_DEPTH; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check_eq("empty_count", int'(bus.free_count_o), 0);

        // Free on empty with same-cycle request: grant only next cycle
        cycle(0, 0, 0, 1, 0);
        cycle(1, 1, 5, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Allocate four, commit two, flush rewinds to the committed head
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("flush_count", int'(bus.free_count_o), 30);
        check_eq("flush_head_preg", int'(bus.alloc_preg_o), 34);
        cycle(1, 0, 0, 0, 0);

        // Steady alloc + commit + free; pointers wrap more than twice
        do_reset(1'b0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) cycle(1, 1, 40 + (i % 24), 1, 0);
        check_eq("steady_count", int'(bus.free_count_o), 30);

        // Reset mid-operation with ten entries left
        do_reset(1'b0);
        for (int i = 0; i < 22; i++) cycle(1, 0, 0, 0, 0);
        check_eq("pre_rst_count", int'(bus.free_count_o), 10);
        do_reset(1'b1);

        // Free of preg 0 is dropped; a legal free still lands
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        check_eq("zero_free_count", int'(bus.free_count_o), 31);
        cycle(0, 1, 7, 0, 0);
        check_eq("legal_free_count", int'(bus.free_count_o), 32);

        check_eq("sb_leftover", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
